// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding and helpers for the keypad scanner
package keypad_pkg;
   typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_e;
   function automatic int code_w(input int rows, input int cols);
      return $clog2(rows * cols);
   endfunction
   function automatic logic [7:0] row_vec(input logic [2:0] idx);
      return ~(8'b1 << idx);
   endfunction
   function automatic logic one_low(input logic [7:0] v, input int n);
      int z;
      z = 0;
      for (int i = 0; i < 8; i++) if (i < n && !v[i]) z++;
      return z == 1;
   endfunction
endpackage

// File: rtl/keypad_col_sync.sv
// keypad_col_sync: two-flop synchroniser for active-low column inputs, idles high
module keypad_col_sync #(
   parameter int COLS = 3
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [COLS-1:0] col_n_i,
   output logic [COLS-1:0] cs_o
);
   logic [COLS-1:0] meta_q, sync_q;
   always_ff @(posedge clk_i)
      if (rst_i) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= col_n_i;
         sync_q <= meta_q;
      end
   assign cs_o = sync_q;
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: row/column keypad scanner with debounce, long press, auto-repeat and event handshake
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int ROWS = 4,
   parameter int COLS = 3,
   parameter int DWELL = 32768,
   parameter int DEBOUNCE = 4096,
   parameter int LONG = 131071,
   parameter int REPEAT_DELAY = 196607,
   parameter int REPEAT_RATE = 65536,
   localparam int CODE_W = code_w(ROWS, COLS)
) (
   input  logic              f4m,
   input  logic              rst,
   input  logic [COLS-1:0]   col_n,
   input  logic              repeat_en,
   output logic [ROWS-1:0]   row_n,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [CODE_W-1:0] evt_code,
   output logic              evt_repeat,
   output logic              key_held,
   output logic              long_press,
   output logic              multi_key,
   output logic              overflow
);
   localparam int DW_W = $clog2(DWELL + 1);
   localparam int DB_W = $clog2(DEBOUNCE + 1);
   localparam int HOLD_MAX = LONG > REPEAT_DELAY ? LONG : REPEAT_DELAY;
   localparam int HD_W = $clog2(HOLD_MAX + 1);
   localparam int RT_W = $clog2(REPEAT_RATE + 1);
   localparam logic [COLS-1:0] IDLE = '1;

   state_e            state_q, state_d;
   logic [COLS-1:0]   cs, pat_q, pat_d;
   logic [2:0]        row_q, row_d, col_q, col_d, col_idx, row_nxt;
   logic [DW_W-1:0]   dwell_q, dwell_d;
   logic [DB_W-1:0]   db_q, db_d;
   logic [HD_W-1:0]   hold_q, hold_d;
   logic [RT_W-1:0]   rate_q, rate_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              valid_q, valid_d, rep_q, rep_d, ovf_q, ovf_d;
   logic              sample, match, idle, single, rep_due, ev_new, ev_rep, load;

   keypad_col_sync #(.COLS(COLS)) u_sync (
      .clk_i(f4m),
      .rst_i(rst),
      .col_n_i(col_n),
      .cs_o(cs)
   );

   always_ff @(posedge f4m)
      if (rst) begin
         state_q <= S_SCAN;
         row_q   <= '0;
         col_q   <= '0;
         pat_q   <= '1;
         dwell_q <= '0;
         db_q    <= '0;
         hold_q  <= '0;
         rate_q  <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         rep_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         pat_q   <= pat_d;
         dwell_q <= dwell_d;
         db_q    <= db_d;
         hold_q  <= hold_d;
         rate_q  <= rate_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         rep_q   <= rep_d;
         ovf_q   <= ovf_d;
      end

   // db_q counts stable-press cycles in DEBOUNCE and idle cycles in RELEASE
   always_comb begin
      col_idx = '0;
      for (int i = COLS - 1; i >= 0; i--) if (!cs[i]) col_idx = 3'(i);
      sample  = state_q == S_SCAN && dwell_q == DW_W'(DWELL - 1);
      match   = cs == pat_q;
      idle    = cs == IDLE;
      single  = one_low(8'(cs), COLS);
      row_nxt = row_q == 3'(ROWS - 1) ? 3'd0 : row_q + 3'd1;
      rep_due = hold_q == HD_W'(REPEAT_DELAY - 1) ||
                (hold_q >= HD_W'(REPEAT_DELAY) && rate_q == RT_W'(REPEAT_RATE - 1));
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      pat_d   = pat_q;
      dwell_d = '0;
      db_d    = '0;
      hold_d  = hold_q;
      rate_d  = rate_q;
      ev_new  = 1'b0;
      ev_rep  = 1'b0;
      case (state_q)
         S_SCAN: begin
            dwell_d = sample ? '0 : dwell_q + 1'b1;
            if (sample && single) begin
               state_d = S_DEBOUNCE;
               col_d   = col_idx;
               pat_d   = cs;
            end else if (sample) row_d = row_nxt;
         end
         S_DEBOUNCE:
            if (!match) state_d = S_SCAN;
            else if (db_q == DB_W'(DEBOUNCE - 1)) begin
               state_d = S_PRESSED;
               ev_new  = 1'b1;
               hold_d  = '0;
               rate_d  = '0;
            end else db_d = db_q + 1'b1;
         S_PRESSED: begin
            hold_d  = &hold_q ? hold_q : hold_q + 1'b1;
            rate_d  = rep_due ? '0 : rate_q + 1'b1;
            ev_new  = repeat_en && rep_due;
            ev_rep  = ev_new;
            state_d = match ? S_PRESSED : S_RELEASE;
         end
         default:
            if (match) state_d = S_PRESSED;
            else if (idle && db_q == DB_W'(DEBOUNCE - 1)) begin
               state_d = S_SCAN;
               row_d   = row_nxt;
            end else if (idle) db_d = db_q + 1'b1;
      endcase
      load    = ev_new && (!valid_q || evt_ready);
      valid_d = load || (valid_q && !evt_ready);
      code_d  = load ? CODE_W'(int'(col_q) * ROWS + int'(row_q)) : code_q;
      rep_d   = load ? ev_rep : rep_q;
      ovf_d   = ovf_q || (ev_new && valid_q && !evt_ready);
   end

   always_comb begin
      row_n      = ROWS'(row_vec(row_q));
      key_held   = state_q == S_PRESSED || state_q == S_RELEASE;
      long_press = state_q == S_PRESSED && hold_q == HD_W'(LONG - 1);
      multi_key  = sample && !idle && !single;
      evt_valid  = valid_q;
      evt_code   = code_q;
      evt_repeat = rep_q;
      overflow   = ovf_q;
   end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: table-driven, directed and randomized checks against a behavioural model
module tb_keypad_scan_ctrl;
   localparam int ROWS = 4, COLS = 3, DWELL = 8, DEB = 4, LONG = 32, RD = 40, RATE = 16;
   localparam int M_SCAN = 0, M_DEB = 1, M_PRESS = 2, M_REL = 3;

   logic       f4m = 1'b0, rst = 1'b0, repeat_en = 1'b0, evt_ready = 1'b0;
   logic [2:0] col_n = 3'b111;
   logic [3:0] row_n, evt_code;
   logic       evt_valid, evt_repeat, key_held, long_press, multi_key, overflow;
   int         checks = 0, errors = 0;
   int         n_long, n_multi, n_xfer, n_rep;

   int         m_mode, m_row, m_dwell, m_db, m_held, m_col;
   logic [2:0] m_pat, m_s1, m_s2;
   logic [3:0] m_code;
   logic       m_valid, m_rep, m_ovf;

   typedef struct {
      int         row;
      logic [2:0] pat;
      logic [3:0] code;
      logic [3:0] rown;
   } press_vec_t;
   press_vec_t vecs[5];
   logic [3:0] idle_rows[5];

   keypad_scan_ctrl #(
      .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .DEBOUNCE(DEB),
      .LONG(LONG), .REPEAT_DELAY(RD), .REPEAT_RATE(RATE)
   ) dut (
      .f4m(f4m), .rst(rst), .col_n(col_n), .repeat_en(repeat_en),
      .row_n(row_n), .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_code(evt_code), .evt_repeat(evt_repeat), .key_held(key_held),
      .long_press(long_press), .multi_key(multi_key), .overflow(overflow)
   );

   always #5 f4m = ~f4m;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_mode = M_SCAN; m_row = 0; m_dwell = 0; m_db = 0; m_held = 0; m_col = 0;
      m_pat = 3'b111; m_s1 = 3'b111; m_s2 = 3'b111;
      m_code = '0; m_valid = 1'b0; m_rep = 1'b0; m_ovf = 1'b0;
   endtask

   function automatic logic [13:0] m_out();
      logic [3:0] rv;
      logic       mk;
      rv = ~(4'b1 << m_row);
      mk = m_mode == M_SCAN && m_dwell == DWELL - 1 && $countones(~m_s2) >= 2;
      return {rv, m_valid, m_code, m_rep, m_mode == M_PRESS || m_mode == M_REL,
              m_mode == M_PRESS && m_held == LONG - 1, mk, m_ovf};
   endfunction

   // Advances the model by one clock using the inputs the DUT will sample at the next edge
   task automatic m_step();
      logic [2:0] cs;
      logic       ev, evr;
      int         z, ci;
      cs = m_s2; ev = 1'b0; evr = 1'b0; ci = 0;
      if (rst) begin
         m_reset();
         return;
      end
      z = $countones(~cs);
      for (int i = 2; i >= 0; i--) if (!cs[i]) ci = i;
      case (m_mode)
         M_SCAN:
            if (m_dwell == DWELL - 1) begin
               m_dwell = 0;
               if (z == 1) begin
                  m_mode = M_DEB; m_pat = cs; m_col = ci; m_db = 0;
               end else m_row = (m_row + 1) % ROWS;
            end else m_dwell++;
         M_DEB:
            if (cs != m_pat) m_mode = M_SCAN;
            else if (m_db == DEB - 1) begin
               ev = 1'b1; m_mode = M_PRESS; m_held = 0;
            end else m_db++;
         M_PRESS: begin
            ev = repeat_en && m_held >= RD - 1 && (m_held - (RD - 1)) % RATE == 0;
            evr = ev;
            m_held++;
            if (cs != m_pat) begin
               m_mode = M_REL; m_db = 0;
            end
         end
         default:
            if (cs == m_pat) m_mode = M_PRESS;
            else if (cs != 3'b111) m_db = 0;
            else if (m_db == DEB - 1) begin
               m_mode = M_SCAN; m_row = (m_row + 1) % ROWS; m_dwell = 0;
            end else m_db++;
      endcase
      if (ev && (!m_valid || evt_ready)) begin
         m_valid = 1'b1; m_code = 4'(m_col * ROWS + m_row); m_rep = evr;
      end else if (ev) m_ovf = 1'b1;
      else if (m_valid && evt_ready) m_valid = 1'b0;
      m_s2 = m_s1;
      m_s1 = col_n;
   endtask

   task automatic tick();
      @(negedge f4m);
      chk("cycle_outputs", {row_n, evt_valid, evt_code, evt_repeat, key_held, long_press, multi_key, overflow}, m_out());
      if (evt_valid && evt_ready) begin
         n_xfer++;
         n_rep += int'(evt_repeat);
      end
      n_long  += int'(long_press);
      n_multi += int'(multi_key);
      m_step();
      @(posedge f4m);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1; col_n = 3'b111;
      tick();
      rst = 1'b0;
      n_long = 0; n_multi = 0; n_xfer = 0; n_rep = 0;
   endtask

   initial begin
      vecs[0] = '{2, 3'b101, 4'd6, 4'b1011};
      vecs[1] = '{3, 3'b110, 4'd3, 4'b0111};
      vecs[2] = '{0, 3'b011, 4'd8, 4'b1110};
      vecs[3] = '{1, 3'b101, 4'd5, 4'b1101};
      vecs[4] = '{3, 3'b011, 4'd11, 4'b0111};
      idle_rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
      n_long = 0; n_multi = 0; n_xfer = 0; n_rep = 0;

      rst = 1'b1;
      repeat (2) @(posedge f4m);
      #1;
      m_reset();
      rst = 1'b0;
      chk("reset_outputs", {row_n, evt_valid, evt_code, evt_repeat, key_held, long_press, multi_key, overflow}, {4'b1110, 10'b0});

      for (int k = 0; k < 5; k++) begin
         chk("idle_row", row_n, idle_rows[k]);
         ticks(8);
      end
      chk("idle_no_event", evt_valid, 1'b0);

      for (int k = 0; k < 5; k++) begin
         do_reset();
         ticks(8 * vecs[k].row);
         col_n = vecs[k].pat;
         ticks(20);
         chk("press_valid", evt_valid, 1'b1);
         chk("press_code", evt_code, vecs[k].code);
         chk("press_repeat", evt_repeat, 1'b0);
         chk("press_row_frozen", row_n, vecs[k].rown);
         chk("press_held", key_held, 1'b1);
         col_n = 3'b111;
         ticks(12);
         chk("release_held", key_held, 1'b0);
      end

      do_reset();
      evt_ready = 1'b1;
      ticks(8);
      for (int k = 0; k < 6; k++) begin
         col_n = 3'b011; ticks(2);
         col_n = 3'b111; ticks(2);
         if (k == 2) chk("bounce_same_row", row_n, 4'b1101);
      end
      chk("bounce_no_event", n_xfer, 0);
      col_n = 3'b011; ticks(20);
      col_n = 3'b111; ticks(20);
      chk("bounce_one_event", n_xfer, 1);

      do_reset();
      repeat_en = 1'b1; evt_ready = 1'b1;
      ticks(24);
      col_n = 3'b110;
      ticks(90);
      col_n = 3'b111;
      ticks(12);
      chk("hold_events", n_xfer, 4);
      chk("hold_repeats", n_rep, 3);
      chk("hold_long_pulses", n_long, 1);
      chk("hold_released", key_held, 1'b0);

      do_reset();
      repeat_en = 1'b1; evt_ready = 1'b0;
      col_n = 3'b101;
      ticks(80);
      chk("bp_valid", evt_valid, 1'b1);
      chk("bp_code", evt_code, 4'd4);
      chk("bp_repeat", evt_repeat, 1'b0);
      chk("bp_overflow", overflow, 1'b1);
      col_n = 3'b111;
      ticks(10);
      evt_ready = 1'b1;
      tick();
      chk("bp_drained", evt_valid, 1'b0);
      evt_ready = 1'b0;
      ticks(5);
      chk("bp_overflow_sticky", overflow, 1'b1);
      do_reset();
      chk("bp_overflow_cleared", overflow, 1'b0);

      evt_ready = 1'b1;
      col_n = 3'b100;
      ticks(6);
      col_n = 3'b111;
      ticks(14);
      chk("multi_pulses", n_multi, 1);
      chk("multi_no_event", n_xfer, 0);
      col_n = 3'b110;
      ticks(12);
      chk("pre_reset_held", key_held, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      col_n = 3'b111;
      chk("midpress_reset", {row_n, evt_valid, evt_code, evt_repeat, key_held, long_press, multi_key, overflow}, {4'b1110, 10'b0});

      do_reset();
      for (int s = 0; s < 160; s++) begin
         int r;
         r = $urandom_range(0, 9);
         col_n = r < 4 ? 3'b111 : r < 8 ? ~(3'b001 << $urandom_range(0, 2)) : 3'($urandom_range(0, 7));
         evt_ready = $urandom_range(0, 3) != 0;
         repeat_en = $urandom_range(0, 1) != 0;
         if ($urandom_range(0, 49) == 0) begin
            rst = 1'b1; tick(); rst = 1'b0;
         end
         ticks($urandom_range(0, 3) == 0 ? $urandom_range(60, 120) : $urandom_range(1, 30));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Parametrised row/column keypad scanner. It is the successor to the fixed 4x3 CPLD scanner.
- Drives one active-low row at a time and samples active-low columns through a synchroniser.
- Debounces both press and release, encodes the key, and hands one event at a time to the downstream logic over a valid/ready handshake.
- Adds features the fixed scanner lacks: long-press pulse, optional auto-repeat, multi-key detection, and a sticky overflow flag.

Parameters:
- ROWS, 4, number of scanned rows (2..8)
- COLS, 3, number of column inputs (1..8)
- DWELL, 32768, clocks each row is driven before the scan advances
- DEBOUNCE, 4096, consecutive stable clocks required to accept a press or a release
- LONG, 131071, hold clocks (counted from acceptance) at which long_press pulses
- REPEAT_DELAY, 196607, hold clocks before the first auto-repeat event
- REPEAT_RATE, 65536, clocks between subsequent auto-repeat events
- CODE_W, $clog2(ROWS*COLS), key code width (derived, never overridden)

Ports:
- f4m  in  1  system clock
- rst  in  1  synchronous reset, active-high
- col_n  in  COLS  column inputs, active-low, asynchronous to f4m
- repeat_en  in  1  enables auto-repeat while a key is held
- row_n  out  ROWS  row drive, exactly one bit low
- evt_valid  out  1  event register holds an unconsumed event
- evt_ready  in  1  consumer accepts the event (transfer = evt_valid & evt_ready)
- evt_code  out  CODE_W  key code = col_idx*ROWS + row_idx
- evt_repeat  out  1  event was produced by auto-repeat
- key_held  out  1  a debounced key is currently down
- long_press  out  1  one-cycle pulse
- multi_key  out  1  one-cycle pulse
- overflow  out  1  sticky, set when an event is dropped

Behaviour:
- Reset (rst=1 on a rising f4m edge):
  - row index 0, so row_n = ~1.
  - State SCAN; all counters 0; synchroniser flops all ones.
  - evt_valid, evt_code, evt_repeat, key_held, long_press, multi_key and overflow are all 0.
  - rst mid-press discards the key and any pending event.
- Synchroniser: col_n passes through a 2-flop synchroniser to give cs. Latency is 2 clocks. "Active" means cs != all-ones.
- State SCAN:
  - The dwell counter counts 0..DWELL-1. cs is sampled only when the counter is at DWELL-1.
  - At the sample point, if cs is all ones, the row index advances and wraps ROWS-1 -> 0.
  - If exactly one cs bit is low, capture col_idx and the pattern, freeze the row, clear db_cnt, and go to DEBOUNCE.
  - If two or more cs bits are low, pulse multi_key, advance the row, and stay in SCAN.
- State DEBOUNCE:
  - Each cycle cs equals the captured pattern, db_cnt increments.
  - On any mismatch, return to SCAN on the same row with the dwell counter cleared.
  - When db_cnt reaches DEBOUNCE-1, produce an event (evt_repeat=0), set key_held, clear hold_cnt, and go to PRESSED.
- State PRESSED:
  - hold_cnt increments and saturates at its maximum.
  - long_press pulses on the single cycle hold_cnt == LONG-1.
  - If repeat_en=1, produce a repeat event (evt_repeat=1) when hold_cnt == REPEAT_DELAY-1, and then every REPEAT_RATE clocks. Taking repeat_en low stops further repeats immediately.
  - Any cs != captured pattern moves to RELEASE with rel_cnt cleared.
- State RELEASE:
  - Counts consecutive all-ones cs cycles. At DEBOUNCE-1, clear key_held and go to SCAN with the row advanced.
  - If cs equals the captured pattern again, return to PRESSED; hold_cnt is kept and keeps counting.
  - Any other non-idle pattern clears rel_cnt.
- Event register (single entry):
  - A produced event loads when evt_valid=0 or evt_ready=1, then evt_valid=1 on the next cycle.
  - Transfer with no new event: evt_valid=0 next cycle.
  - Transfer and new event in the same cycle: the new event loads and evt_valid stays 1.
  - New event while evt_valid=1 and evt_ready=0: the event is dropped and overflow is set. overflow clears only on rst.
  - evt_code and evt_repeat hold steady while evt_valid=1 and evt_ready=0.
- Press latency: evt_valid rises DEBOUNCE+1 clocks after the SCAN sample cycle that detected the key.
- Codes ROWS*COLS .. 2^CODE_W-1 are never produced.

Decomposition:
- Package keypad_pkg holds:
  - the state enum (SCAN, DEBOUNCE, PRESSED, RELEASE);
  - a function computing CODE_W;
  - a function returning a one-hot-low row vector;
  - a function testing "exactly one bit low".
- One sub-module, keypad_col_sync: a COLS-wide 2-flop synchroniser with reset value all ones.
- Everything else (scan, FSM, hold timer, event register) lives in the top module.

Test Plan:
All scenarios use ROWS=4, COLS=3, DWELL=8, DEBOUNCE=4, LONG=32, REPEAT_DELAY=40, REPEAT_RATE=16.
- Idle scan: rst, then col_n=3'b111 -> row_n cycles 1110,1101,1011,0111 with 8 clocks each, wraps, and evt_valid stays 0.
- Single press: col_n=3'b101 held while row 2 is low, evt_ready=1 -> one event with evt_code=6 (1*4+2) and evt_repeat=0; key_held=1; row_n frozen at 1011.
- Bounce: col toggled every 2 clocks during DEBOUNCE -> no event, scan resumes on the same row; a stable press after that gives exactly one event.
- Hold with repeat_en=1: key at row 3, col 0 held for 80 clocks -> initial event code 3; long_press pulses at hold_cnt 31; repeat events (evt_repeat=1, code 3) at hold_cnt 39 and 55, plus the one due at 71 if the hold lasts that long. After release, key_held drops after 4 idle clocks.
- Backpressure: evt_ready=0 through the press and the repeats -> the first event is held steady, the repeats are dropped, and overflow=1. Then evt_ready=1 -> evt_valid=0 the next cycle, and overflow stays 1 until rst.
- Multi-key and reset: col_n=3'b100 -> one multi_key pulse and no event. rst asserted while in PRESSED -> every output is 0 and row_n=1110 on the next cycle.
